use_hint_pipe: RTL and testbench
================================

Name: use_hint_pipe

Overview:
- Multi-lane, pipelined UseHint unit for the Dilithium/ML-DSA verify datapath.
- Applies hints to w'-approximation coefficients and produces w1 coefficients ready for packing and hashing.
- Supports both gamma2 parameter sets, selected per beat: ML-DSA-65/87 (gamma2=(q-1)/32) and ML-DSA-44 (gamma2=(q-1)/88).
- Accumulates the per-polynomial hint population count and checks it against omega.

Parameters:
- LANES, 4, coefficients processed per beat.
- CW, 23, coefficient width (q=8380417 < 2^23).
- A1W, 6, output a1 width per lane (max value 43).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  per beat: 0 = gamma2 (q-1)/32 (m=16); 1 = gamma2 (q-1)/88 (m=44).
- omega  in  8  hint-count limit (80/55/75); sampled on the beat carrying in_last.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  LANES*CW  coefficients; lane i = bits [i*CW +: CW].
- in_hint  in  LANES  hint bit per lane.
- in_last  in  1  last beat of a polynomial.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_a1  out  LANES*A1W  adjusted high bits, zero-extended.
- out_last  out  1  mirrors in_last of the beat.
- out_hint_cnt  out  8  saturating hint total for the polynomial; valid only when out_last=1, otherwise 0.
- out_omega_err  out  1  out_hint_cnt > omega; valid only when out_last=1, otherwise 0.

Behaviour:
- Reset (async, rst_n=0): all valid flags, out_a1, out_last, out_hint_cnt, out_omega_err and the hint accumulator go to 0. A beat in flight when reset asserts is dropped; nothing is replayed.
- Pipeline: 2 register stages, latency 2 cycles from acceptance to out_valid when no stall.
  - S1: range fold, decompose, carry hint/mode/last.
  - S2: hint adjust, drive outputs.
- Handshake: en = !out_valid || out_ready; in_ready = en; both stages advance only when en=1.
  - Stalled outputs and out_valid hold stable.
  - Bubbles propagate as valid=0.
  - Full throughput of 1 beat/cycle when out_ready=1.
- Range fold: a+ = (a >= q) ? a - q : a. One subtraction suffices because 2^23 < 2q.
- Decompose (per lane, 2g = 2*gamma2):
  - a0 = a+ mod± 2g, centered in (-gamma2, gamma2].
  - If a+ - a0 == q-1: a1 = 0, a0 = a0 - 1.
  - Else: a1 = (a+ - a0)/2g.
  - Division-free implementation (FIPS 204 reference style), with f = (a+ + 127) >> 7:
    - mode0: a1 = ((f*1025 + 2^21) >> 22) & 15.
    - mode1: a1 = (f*11275 + 2^23) >> 24; if a1 > 43 then a1 = 0.
    - a0 = a+ - a1*2g; if a0 > (q-1)/2 then a0 -= q.
  - a0 is held signed, at least 24 bits.
- UseHint:
  - hint=0 → a1.
  - hint=1, a0 > 0 → (a1+1) mod m.
  - hint=1, a0 ≤ 0 → (a1-1) mod m.
  - Wrap-around: m-1 → 0 and 0 → m-1, with m=16 for mode0 and m=44 for mode1.
- Hint accumulator:
  - On each accepted beat, acc ← sat255(acc + popcount(in_hint)).
  - On an accepted beat with in_last=1, the final total (including that beat) and the omega comparison travel with the beat, and acc clears to 0 in the same cycle.
  - Back-to-back polynomials need no gap.
- Mode may change beat to beat; each lane result uses the mode of its own beat.
- Out of contract: mode changing within one polynomial. Results are then still computed per beat with no checking.

Decomposition:
- Shared package dilithium_pkg holds:
  - Q=8380417, GAMMA2_32=261888, GAMMA2_88=95232, M_32=16, M_88=44.
  - Multiply/shift constants 1025/22 and 11275/24.
  - Mode encoding.
- Sub-module use_hint_lane: combinational single-coefficient fold + decompose + adjust, split by an internal register boundary passed as ports. It is instantiated LANES times.
- The top level owns the handshake, the hint accumulator and the output registers.

Test Plan:
- mode0, hint=1, a ∈ {0, 8380416, 523777, 261888} → a1 ∈ {15, 15, 2, 1}; same inputs with hint=0 → {0, 0, 1, 0}.
- mode1, a=8189957 (a1=43, a0=5), hint=1 → 0. Also a=0, hint=1 → 43; a=8380416, hint=0 → 0.
- a=8380417 (=q), mode0, hint=1 → 15, i.e. folded to 0.
- Backpressure: stream 8 beats with out_ready toggling 1,0,0,1,… → no loss or duplication, outputs stable while stalled, order preserved, latency 2 when unstalled.
- Polynomial of 64 beats, LANES=4, with 81 hints set, omega=80 → last beat: out_hint_cnt=81, out_omega_err=1. The next polynomial with 3 hints reports 3, err=0.
- Assert rst_n low with 2 beats in flight → out_valid=0 immediately, accumulator 0. The next polynomial counts from 0.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants for the UseHint datapath: modulus, gamma2 variants,
// wrap moduli and the division-free decompose multipliers.
package dilithium_pkg;

    typedef enum logic {
        MODE_32 = 1'b0,
        MODE_88 = 1'b1
    } mode_t;

    localparam int A0W = 24;

    localparam logic [31:0] Q         = 32'd8380417;
    localparam logic [31:0] HALF_Q    = 32'd4190208;
    localparam logic [31:0] GAMMA2_32 = 32'd261888;
    localparam logic [31:0] GAMMA2_88 = 32'd95232;
    localparam logic [31:0] M_32      = 32'd16;
    localparam logic [31:0] M_88      = 32'd44;

    localparam logic [31:0] MUL_32 = 32'd1025;
    localparam int          SH_32  = 22;
    localparam logic [31:0] RND_32 = 32'd1 << (SH_32 - 1);
    localparam logic [31:0] MUL_88 = 32'd11275;
    localparam int          SH_88  = 24;
    localparam logic [31:0] RND_88 = 32'd1 << (SH_88 - 1);

endpackage

// File: rtl/use_hint_lane.sv
// One coefficient of UseHint: fold + decompose on the S1 side, hint adjust on
// the S2 side. The register boundary between the halves lives in the top.
module use_hint_lane
    import dilithium_pkg::*;
#(
    parameter int CW  = 23,
    parameter int A1W = 6
) (
    input  logic [CW-1:0]         a,
    input  mode_t                 mode,
    output logic [A1W-1:0]        a1,
    output logic signed [A0W-1:0] a0,
    input  logic [A1W-1:0]        a1_reg,
    input  logic signed [A0W-1:0] a0_reg,
    input  logic                  hint_reg,
    input  mode_t                 mode_reg,
    output logic [A1W-1:0]        a1_adj
);

    logic [31:0] a_ext;
    logic [31:0] a_fold;
    logic [31:0] f;
    logic [31:0] p32;
    logic [31:0] p88;
    logic [31:0] a1_ext;
    logic [31:0] two_g;
    logic [31:0] a0_w;
    logic [A1W-1:0] m;

    // Inputs never exceed 2^23 < 2q, so a single conditional subtract folds them.
    always_comb begin
        a_ext  = 32'(a);
        a_fold = (a_ext >= Q) ? a_ext - Q : a_ext;
        f      = (a_fold + 32'd127) >> 7;
        p32    = (f * MUL_32 + RND_32) >> SH_32;
        p88    = (f * MUL_88 + RND_88) >> SH_88;
        if (mode == MODE_88) begin
            a1_ext = (p88 > (M_88 - 32'd1)) ? 32'd0 : p88;
            two_g  = GAMMA2_88 << 1;
        end else begin
            a1_ext = p32 & (M_32 - 32'd1);
            two_g  = GAMMA2_32 << 1;
        end
        a0_w = a_fold - a1_ext * two_g;
        if ($signed(a0_w) > $signed(HALF_Q)) begin
            a0_w = a0_w - Q;
        end
        a1 = a1_ext[A1W-1:0];
        a0 = a0_w[A0W-1:0];
    end

    always_comb begin
        m      = (mode_reg == MODE_88) ? M_88[A1W-1:0] : M_32[A1W-1:0];
        a1_adj = a1_reg;
        if (hint_reg) begin
            if (a0_reg > 0) begin
                a1_adj = (a1_reg == m - 1'b1) ? '0 : a1_reg + 1'b1;
            end else begin
                a1_adj = (a1_reg == '0) ? m - 1'b1 : a1_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/use_hint_pipe.sv
// Multi-lane pipelined UseHint with per-polynomial hint counting and omega check.
// S1 registers the decomposed coefficients; S2 registers the adjusted outputs.
module use_hint_pipe
    import dilithium_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CW    = 23,
    parameter int A1W   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [7:0]             omega,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*CW-1:0]    in_a,
    input  logic [LANES-1:0]       in_hint,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*A1W-1:0]   out_a1,
    output logic                   out_last,
    output logic [7:0]             out_hint_cnt,
    output logic                   out_omega_err
);

    logic       en;
    logic       accept;
    logic       last_beat;
    mode_t      mode_in;
    logic [7:0] acc;
    logic [8:0] pop;
    logic [8:0] acc_sum;
    logic [7:0] acc_next;

    logic [A1W-1:0]        dec_a1 [LANES];
    logic signed [A0W-1:0] dec_a0 [LANES];
    logic [A1W-1:0]        adj_a1 [LANES];

    logic                  s1_valid;
    mode_t                 s1_mode;
    logic [LANES-1:0]      s1_hint;
    logic                  s1_last;
    logic [7:0]            s1_cnt;
    logic                  s1_err;
    logic [A1W-1:0]        s1_a1 [LANES];
    logic signed [A0W-1:0] s1_a0 [LANES];

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign last_beat = in_valid && in_last;
    assign mode_in   = mode_t'(mode);

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + 9'(in_hint[i]);
        end
        acc_sum  = {1'b0, acc} + pop;
        acc_next = acc_sum[8] ? 8'hFF : acc_sum[7:0];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        use_hint_lane #(
            .CW  (CW),
            .A1W (A1W)
        ) u_lane (
            .a        (in_a[i*CW +: CW]),
            .mode     (mode_in),
            .a1       (dec_a1[i]),
            .a0       (dec_a0[i]),
            .a1_reg   (s1_a1[i]),
            .a0_reg   (s1_a0[i]),
            .hint_reg (s1_hint[i]),
            .mode_reg (s1_mode),
            .a1_adj   (adj_a1[i])
        );
    end

    // The closing beat of a polynomial carries the total away and restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= in_last ? 8'd0 : acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_32;
            s1_hint  <= '0;
            s1_last  <= 1'b0;
            s1_cnt   <= '0;
            s1_err   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_a1[i] <= '0;
                s1_a0[i] <= '0;
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mode  <= mode_in;
            s1_hint  <= in_hint;
            s1_last  <= last_beat;
            s1_cnt   <= last_beat ? acc_next : 8'd0;
            s1_err   <= last_beat && (acc_next > omega);
            for (int i = 0; i < LANES; i++) begin
                s1_a1[i] <= dec_a1[i];
                s1_a0[i] <= dec_a0[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_a1        <= '0;
            out_last      <= 1'b0;
            out_hint_cnt  <= '0;
            out_omega_err <= 1'b0;
        end else if (en) begin
            out_valid     <= s1_valid;
            out_last      <= s1_valid && s1_last;
            out_hint_cnt  <= (s1_valid && s1_last) ? s1_cnt : 8'd0;
            out_omega_err <= s1_valid && s1_last && s1_err;
            for (int i = 0; i < LANES; i++) begin
                out_a1[i*A1W +: A1W] <= adj_a1[i];
            end
        end
    end

endmodule

// File: tb/tb_use_hint_pipe.sv
// Randomized bench for use_hint_pipe against a decompose/UseHint model written
// from the mathematical definitions, with literal pins on known vectors.
module tb_use_hint_pipe;

    localparam int LANES = 4;
    localparam int CW    = 23;
    localparam int A1W   = 6;
    localparam int QI    = 8380417;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [7:0]           omega;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*CW-1:0]  in_a;
    logic [LANES-1:0]     in_hint;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*A1W-1:0] out_a1;
    logic                 out_last;
    logic [7:0]           out_hint_cnt;
    logic                 out_omega_err;

    use_hint_pipe #(.LANES(LANES), .CW(CW), .A1W(A1W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .omega         (omega),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_hint       (in_hint),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_a1        (out_a1),
        .out_last      (out_last),
        .out_hint_cnt  (out_hint_cnt),
        .out_omega_err (out_omega_err)
    );

    typedef struct {
        logic [LANES*A1W-1:0] a1;
        logic                 last;
        logic [7:0]           cnt;
        logic                 err;
        bit                   lit_a;
        logic [LANES*A1W-1:0] lit_a1;
        bit                   lit_c;
        logic [7:0]           lit_cnt;
        logic                 lit_err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   acc_m  = 0;
    bit   stall_prev = 0;
    int   ready_mode = 0;
    int   pat_idx = 0;

    bit                   pend_lit_a = 0;
    logic [LANES*A1W-1:0] pend_lit_a1 = '0;
    bit                   pend_lit_c = 0;
    logic [7:0]           pend_lit_cnt = '0;
    logic                 pend_lit_err = 1'b0;

    int bnd[16] = '{0, 1, 8380416, 8380417, 8388607, 261888, 261889, 523776,
                    523777, 95232, 95233, 190464, 8189952, 8189957, 8380415, 4190208};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Centered decomposition by plain division, then the hint rule.
    function automatic int model_a1(input int a, input bit md, input bit h);
        int ap, g, tg, m, r, a1;
        ap = (a >= QI) ? a - QI : a;
        g  = md ? 95232 : 261888;
        m  = md ? 44 : 16;
        tg = 2 * g;
        r  = ap % tg;
        if (r > g) r = r - tg;
        if (ap - r == QI - 1) begin
            a1 = 0;
            r  = r - 1;
        end else begin
            a1 = (ap - r) / tg;
        end
        if (h) a1 = (r > 0) ? (a1 + 1) % m : (a1 + m - 1) % m;
        return a1;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = (pat_idx % 3 == 0);
                    pat_idx++;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   pc;
        if (rst_n) begin
            if (stall_prev) check("stall_hold", int'(out_valid), 1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = q[0];
                    for (int i = 0; i < LANES; i++) begin
                        check($sformatf("a1_lane%0d", i), int'(out_a1[i*A1W +: A1W]), int'(e.a1[i*A1W +: A1W]));
                        if (e.lit_a) check($sformatf("lit_a1_lane%0d", i), int'(out_a1[i*A1W +: A1W]), int'(e.lit_a1[i*A1W +: A1W]));
                    end
                    check("last", int'(out_last), int'(e.last));
                    check("hint_cnt", int'(out_hint_cnt), int'(e.cnt));
                    check("omega_err", int'(out_omega_err), int'(e.err));
                    if (e.lit_c) begin
                        check("lit_hint_cnt", int'(out_hint_cnt), int'(e.lit_cnt));
                        check("lit_omega_err", int'(out_omega_err), int'(e.lit_err));
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                pc = 0;
                for (int i = 0; i < LANES; i++) begin
                    e.a1[i*A1W +: A1W] = A1W'(model_a1(int'(in_a[i*CW +: CW]), mode, in_hint[i]));
                    pc += int'(in_hint[i]);
                end
                acc_m = (acc_m + pc > 255) ? 255 : acc_m + pc;
                e.last = in_last;
                if (in_last) begin
                    e.cnt = 8'(acc_m);
                    e.err = (acc_m > int'(omega));
                    acc_m = 0;
                end else begin
                    e.cnt = 8'd0;
                    e.err = 1'b0;
                end
                e.lit_a   = pend_lit_a;
                e.lit_a1  = pend_lit_a1;
                e.lit_c   = pend_lit_c;
                e.lit_cnt = pend_lit_cnt;
                e.lit_err = pend_lit_err;
                pend_lit_a = 0;
                pend_lit_c = 0;
                q.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic md, input logic [7:0] om, input logic [LANES*CW-1:0] a,
                                 input logic [LANES-1:0] h, input logic last);
        int w;
        mode = md;
        omega = om;
        in_a = a;
        in_hint = h;
        in_last = last;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [LANES*CW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
    endfunction

    function automatic logic [LANES*A1W-1:0] lit4(input int v0, input int v1, input int v2, input int v3);
        return {A1W'(v3), A1W'(v2), A1W'(v1), A1W'(v0)};
    endfunction

    function automatic int rand_coef();
        if ($urandom_range(0, 3) == 0) return bnd[$urandom_range(0, 15)];
        return int'($urandom_range(0, 8388607));
    endfunction

    task automatic send_poly(input logic md, input int nbeats);
        logic [LANES*CW-1:0] a;
        for (int b = 0; b < nbeats; b++) begin
            for (int i = 0; i < LANES; i++) a[i*CW +: CW] = CW'(rand_coef());
            applyStimulus(md, 8'($urandom_range(0, 8)), a, 4'($urandom_range(0, 15)), b == nbeats - 1);
        end
    endtask

    task automatic checkOutput();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [3:0] h;
        rst_n = 1'b0;
        mode = 1'b0;
        omega = 8'd80;
        in_valid = 1'b0;
        in_a = '0;
        in_hint = '0;
        in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_a1", int'(out_a1), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_hint_cnt", int'(out_hint_cnt), 0);
        check("rst_omega_err", int'(out_omega_err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pend_lit_a = 1; pend_lit_a1 = lit4(15, 15, 2, 1);
        pend_lit_c = 1; pend_lit_cnt = 8'd4; pend_lit_err = 1'b0;
        applyStimulus(1'b0, 8'd80, pack4(0, 8380416, 523777, 261888), 4'b1111, 1'b1);
        check("latency_s1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("latency_2", int'(out_valid), 1);

        pend_lit_a = 1; pend_lit_a1 = lit4(0, 0, 1, 0);
        applyStimulus(1'b0, 8'd80, pack4(0, 8380416, 523777, 261888), 4'b0000, 1'b1);
        pend_lit_a = 1; pend_lit_a1 = lit4(0, 43, 0, 43);
        applyStimulus(1'b1, 8'd55, pack4(8189957, 0, 8380416, 8380417), 4'b1011, 1'b1);
        pend_lit_a = 1; pend_lit_a1 = lit4(15, 0, 0, 0);
        applyStimulus(1'b0, 8'd80, pack4(8380417, 8380417, 8380418, 8388607), 4'b0001, 1'b1);
        checkOutput();

        ready_mode = 2;
        send_poly(1'b0, 3);
        send_poly(1'b1, 5);
        checkOutput();

        ready_mode = 1;
        for (int b = 0; b < 64; b++) begin
            h = (b < 20) ? 4'b1111 : ((b == 20) ? 4'b0100 : 4'b0000);
            if (b == 63) begin
                pend_lit_c = 1; pend_lit_cnt = 8'd81; pend_lit_err = 1'b1;
            end
            applyStimulus(1'b0, 8'd80, pack4(rand_coef(), rand_coef(), rand_coef(), rand_coef()), h, b == 63);
        end
        applyStimulus(1'b0, 8'd80, pack4(rand_coef(), rand_coef(), rand_coef(), rand_coef()), 4'b0011, 1'b0);
        pend_lit_c = 1; pend_lit_cnt = 8'd3; pend_lit_err = 1'b0;
        applyStimulus(1'b0, 8'd80, pack4(rand_coef(), rand_coef(), rand_coef(), rand_coef()), 4'b1000, 1'b1);
        checkOutput();

        ready_mode = 0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'd80, pack4(1, 2, 3, 4), 4'b1111, 1'b0);
        applyStimulus(1'b0, 8'd80, pack4(5, 6, 7, 8), 4'b1111, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_hint_cnt", int'(out_hint_cnt), 0);
        q.delete();
        acc_m = 0;
        stall_prev = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend_lit_c = 1; pend_lit_cnt = 8'd2; pend_lit_err = 1'b0;
        applyStimulus(1'b0, 8'd80, pack4(9, 10, 11, 12), 4'b0110, 1'b1);
        checkOutput();

        ready_mode = 1;
        for (int p = 0; p < 40; p++) send_poly(1'($urandom_range(0, 1)), int'($urandom_range(1, 8)));
        checkOutput();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
